// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan
//   Captures a packed BCD vector on i_DV and scans it onto a time-multiplexed
//   seven-segment display. Each digit is driven for CLK_DIV cycles and is
//   followed by BLANK_CYCLES cycles with every enable off, which prevents
//   ghosting between digits.
//
//   Ports:
//     i_Clock       system clock, rising edge
//     i_Rst_n       asynchronous active-low reset
//     i_BCD         packed BCD, digit 0 in bits [3:0]
//     i_DV          single-cycle strobe that loads i_BCD
//     o_Segments    {g,f,e,d,c,b,a}, active-high
//     o_Digit_En    one-hot digit enable, bit n drives digit n
//     o_Frame_Done  one-cycle pulse on the first drive cycle of digit 0
//                   after the index wraps
//
//   Build option:
//     BCD_SEVENSEG_LEADING_ZERO_BLANK_EN  blank leading zeros (digit 0 never
//                                         blanked, invalid codes are nonzero)
module bcd_sevenseg_scan #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYCLES   = 16
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_DV,
    output logic [6:0]                  o_Segments,
    output logic [DECIMAL_DIGITS-1:0]   o_Digit_En,
    output logic                        o_Frame_Done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DECIMAL_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DECIMAL_DIGITS*4-1:0] cap_q, cap_d;
    logic [6:0]                  seg_q, seg_d;
    logic [DECIMAL_DIGITS-1:0]   en_q, en_d;
    logic                        fd_q, fd_d;

    logic                        enter;   // a digit is entering S_DRIVE
    logic [3:0]                  nib;     // nibble of the entering digit
    logic                        blank;   // entering digit is a leading zero
`ifdef BCD_SEVENSEG_LEADING_ZERO_BLANK_EN
    logic                        zero_above;
`endif

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;   // invalid BCD shows a dash
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        // cap_d is also the data source for a digit entered this cycle, so a
        // strobe coincident with entry is shown immediately
        cap_d   = i_DV ? i_BCD : cap_q;
        seg_d   = seg_q;
        en_d    = en_q;
        fd_d    = 1'b0;
        enter   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_DV) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    enter   = 1'b1;
                end
            end
            S_DRIVE: begin
                if (cnt_q == DRV_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    seg_d   = '0;
                    en_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                    enter   = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        fd_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // select the entering digit; walk top-down so the leading-zero run
        // is known by the time the selected digit is reached
        nib   = '0;
        blank = 1'b0;
`ifdef BCD_SEVENSEG_LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
`endif
        for (int n = DECIMAL_DIGITS - 1; n >= 0; n--) begin
`ifdef BCD_SEVENSEG_LEADING_ZERO_BLANK_EN
            zero_above = zero_above && (cap_d[n*4 +: 4] == 4'd0);
`endif
            if (idx_d == IDX_W'(n)) begin
                nib = cap_d[n*4 +: 4];
`ifdef BCD_SEVENSEG_LEADING_ZERO_BLANK_EN
                blank = zero_above && (n != 0);
`endif
            end
        end

        if (enter) begin
            for (int n = 0; n < DECIMAL_DIGITS; n++) begin
                en_d[n] = (idx_d == IDX_W'(n));
            end
            seg_d = blank ? 7'h00 : decode(nib);
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cap_q   <= '0;
            seg_q   <= '0;
            en_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
        end
    end

    assign o_Segments   = seg_q;
    assign o_Digit_En   = en_q;
    assign o_Frame_Done = fd_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Testbench for bcd_sevenseg_scan (4 digits, CLK_DIV=4, BLANK_CYCLES=2).
// A timeline model (cycle count since the first strobe, divided into digit
// slots) predicts every output cycle; vector tables and hand sequences cover
// decode, period, mid-drive update, async reset and coincident capture.
module tb_bcd_sevenseg_scan;

    localparam int DD = 4;
    localparam int CD = 4;
    localparam int BC = 2;
    localparam int P  = CD + BC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd = '0;
    logic        dv = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  en;
    logic        fd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bcd_sevenseg_scan #(.DECIMAL_DIGITS(DD), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_BCD(bcd), .i_DV(dv),
        .o_Segments(seg), .o_Digit_En(en), .o_Frame_Done(fd)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic        started;
        int          t;
        logic [15:0] cap;
        logic [15:0] vec;
        logic [6:0]  seg;
        logic [3:0]  en;
        logic        fd;
    } model_t;

    model_t m = '{1'b0, 0, 16'h0, 16'h0, 7'h0, 4'h0, 1'b0};

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d > 4'd9) ? 7'h40 : tbl[d];
    endfunction

    function automatic logic lz_blank(input logic [15:0] v, input int d);
`ifdef BCD_SEVENSEG_LEADING_ZERO_BLANK_EN
        return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
        return (v == 16'hFFFF) && (d < 0);   // never true
`endif
    endfunction

    function automatic model_t step(input model_t s, input logic dv_i, input logic [15:0] bcd_i);
        model_t r;
        int slot, d;
        r = s;
        r.cap = dv_i ? bcd_i : s.cap;
        r.seg = '0;
        r.en  = '0;
        r.fd  = 1'b0;
        if (!s.started) begin
            if (!dv_i) return r;
            r.started = 1'b1;
            r.t = 0;
        end else begin
            r.t = s.t + 1;
        end
        slot = r.t % P;
        d    = (r.t / P) % DD;
        if (slot == 0) r.vec = r.cap;
        if (slot < CD) begin
            r.en  = 4'(1 << d);
            r.seg = lz_blank(r.vec, d) ? 7'h00 : dec(r.vec[d*4 +: 4]);
            r.fd  = (slot == 0) && (d == 0) && (r.t > 0);
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{1'b0, 0, 16'h0, 16'h0, 7'h0, 4'h0, 1'b0};
        else        m <= step(m, dv, bcd);
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check("scoreboard", 32'({seg, en, fd}), 32'({m.seg, m.en, m.fd}));
    endtask

    task automatic do_reset();
        dv = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic apply(input logic [15:0] v);
        dv = 1'b1;
        bcd = v;
        tick();
        dv = 1'b0;
    endtask

    task automatic wait_en(input logic [3:0] target);
        int k;
        k = 0;
        while (en !== target && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("wait_en_timeout", 32'(en), 32'(target));
    endtask

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0][6:0] off;   // digit3..digit0
        logic [3:0][6:0] lz;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int t0, nz, k;

        tbl[0] = '{16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}};
        tbl[1] = '{16'h00A9, {7'h3F, 7'h3F, 7'h40, 7'h6F}, {7'h00, 7'h00, 7'h40, 7'h6F}};
        tbl[2] = '{16'h0070, {7'h3F, 7'h3F, 7'h07, 7'h3F}, {7'h00, 7'h00, 7'h07, 7'h3F}};
        tbl[3] = '{16'h0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F}};
        tbl[4] = '{16'h9FBC, {7'h6F, 7'h40, 7'h40, 7'h40}, {7'h6F, 7'h40, 7'h40, 7'h40}};
        tbl[5] = '{16'h5068, {7'h6D, 7'h3F, 7'h7D, 7'h7F}, {7'h6D, 7'h3F, 7'h7D, 7'h7F}};

        // reset state
        tick();
        tick();
        check("reset_seg", 32'(seg), 32'(0));
        check("reset_en", 32'(en), 32'(0));
        check("reset_fd", 32'(fd), 32'(0));
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_en", 32'(en), 32'(0));

        // decode table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            apply(tbl[i].bcd);
            for (int n = 0; n < DD; n++) begin
                wait_en(4'(1 << n));
                check("enable", 32'(en), 32'(1 << n));
`ifdef BCD_SEVENSEG_LEADING_ZERO_BLANK_EN
                check("decode_lz", 32'(seg), 32'(tbl[i].lz[n]));
`else
                check("decode", 32'(seg), 32'(tbl[i].off[n]));
`endif
            end
        end

        // basic scan and frame period
        do_reset();
        apply(16'h1234);
        t0 = cyc;
        check("first_en", 32'(en), 32'(4'b0001));
        check("first_fd", 32'(fd), 32'(0));
        for (int j = 1; j < CD; j++) begin
            tick();
            check("hold_seg", 32'(seg), 32'(7'h66));
        end
        for (int j = 0; j < BC; j++) begin
            tick();
            check("blank", 32'({seg, en}), 32'(0));
        end
        k = 0;
        while (fd !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("frame_period", 32'(cyc - t0), 32'(DD * P));
        check("frame_en", 32'(en), 32'(4'b0001));

        // mid-drive update
        wait_en(4'b0010);
        dv = 1'b1;
        bcd = 16'h8888;
        for (int j = 0; j < CD - 1; j++) begin
            tick();
            dv = 1'b0;
            check("middrive_hold", 32'({en, seg}), 32'({4'b0010, 7'h4F}));
        end
        wait_en(4'b0100);
        check("middrive_next", 32'(seg), 32'(7'h7F));

        // asynchronous reset mid-drive
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg", 32'(seg), 32'(0));
        check("async_rst_en", 32'(en), 32'(0));
        check("async_rst_fd", 32'(fd), 32'(0));
        tick();
        rst_n = 1'b1;
        nz = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (en != 0 || seg != 0) nz++;
        end
        check("stay_idle", 32'(nz), 32'(0));

        // capture coincident with blank->drive of digit 0
        apply(16'h1234);
        wait_en(4'b1000);
        repeat (CD + BC - 1) tick();
        dv = 1'b1;
        bcd = 16'h0005;
        tick();
        dv = 1'b0;
        check("coinc_en", 32'(en), 32'(4'b0001));
        check("coinc_seg", 32'(seg), 32'(7'h6D));
        check("coinc_fd", 32'(fd), 32'(1));

        // randomized traffic against the model
        for (int r = 0; r < 6; r++) begin
            do_reset();
            repeat ($urandom_range(0, 7)) tick();
            for (int j = 0; j < 300; j++) begin
                dv = ($urandom_range(0, 39) == 0);
                for (int n = 0; n < DD; n++) bcd[n*4 +: 4] = 4'($urandom_range(0, 11));
                tick();
            end
            dv = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
